// File: rtl/game_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_pkg : shared screen geometry, coordinate widths and FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package game_pkg;

  localparam int c_screen_w    = 640;
  localparam int c_screen_h    = 480;
  localparam int c_x_w         = 10;
  localparam int c_y_w         = 9;
  localparam int c_proj_w      = 10;
  localparam int c_proj_h      = 15;
  localparam int c_num_entries = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_MOVE  = 2'd2,
    ST_HIT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/proj_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proj_slot : one projectile slot with load/move/kill control and hit flags
// Rev 1.0
// ----------------------------------------------------------------------------
module proj_slot
  import game_pkg::*;
#(
  parameter int PROJ_SPEED = 4,
  parameter int SCREEN_H   = c_screen_h
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [c_x_w-1:0] load_x,
  input  logic [c_y_w-1:0] load_y,
  input  logic [c_x_w-1:0] load_w,
  input  logic [c_y_w-1:0] load_h,
  input  logic             move,
  input  logic             kill,
  input  logic [c_x_w-1:0] player_x,
  input  logic [c_y_w-1:0] player_y,
  input  logic [c_x_w-1:0] player_w,
  input  logic [c_y_w-1:0] player_h,
  input  logic [c_x_w-1:0] pix_x,
  input  logic [c_y_w-1:0] pix_y,
  output logic             active,
  output logic             offscreen,
  output logic             hits_player,
  output logic             covers_pixel
);

  logic             active_q, active_d;
  logic [c_x_w-1:0] x_q, x_d, w_q, w_d;
  logic [c_y_w-1:0] y_q, y_d, h_q, h_d;
  logic [9:0]       y_next;
  logic [10:0]      sx_end, px_end, sy_end, py_end;

  // Advance is evaluated one bit wider so a wrap past 511 cannot hide a retire.
  assign y_next = {1'b0, y_q} + 10'(PROJ_SPEED);
  assign sx_end = {1'b0, x_q} + {1'b0, w_q};
  assign px_end = {1'b0, player_x} + {1'b0, player_w};
  assign sy_end = {2'b0, y_q} + {2'b0, h_q};
  assign py_end = {2'b0, player_y} + {2'b0, player_h};

  assign active       = active_q;
  assign offscreen    = active_q && (y_next >= 10'(SCREEN_H));
  assign hits_player  = active_q && ({1'b0, x_q} < px_end) && ({1'b0, player_x} < sx_end)
                        && ({2'b0, y_q} < py_end) && ({2'b0, player_y} < sy_end);
  assign covers_pixel = active_q && (pix_x >= x_q) && ({1'b0, pix_x} < sx_end)
                        && (pix_y >= y_q) && ({2'b0, pix_y} < sy_end);

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    if (load) begin
      active_d = 1'b1;
      x_d      = load_x;
      y_d      = load_y;
      w_d      = load_w;
      h_d      = load_h;
    end else if (kill) begin
      active_d = 1'b0;
    end else if (move && active_q) begin
      y_d = y_next[c_y_w-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/boss_proj_manager.sv
`default_nettype none
// ----------------------------------------------------------------------------
// boss_proj_manager : captures boss volleys into a slot pool, moves and retires them
// Rev 1.0
// ----------------------------------------------------------------------------
module boss_proj_manager
  import game_pkg::*;
#(
  parameter int NUM_SLOTS  = 16,
  parameter int PROJ_SPEED = 4,
  parameter int SCREEN_H   = c_screen_h
) (
  input  logic       clk_master,
  input  logic       rst,
  input  logic       pulse_frame,
  input  logic       bossShoot,
  input  logic [9:0] proj1X,
  input  logic [8:0] proj1Y,
  input  logic [9:0] proj2X,
  input  logic [8:0] proj2Y,
  input  logic [9:0] proj3X,
  input  logic [8:0] proj3Y,
  input  logic [9:0] proj4X,
  input  logic [8:0] proj4Y,
  input  logic [9:0] proj5X,
  input  logic [8:0] proj5Y,
  input  logic [9:0] projW,
  input  logic [8:0] projH,
  input  logic [9:0] playerX,
  input  logic [8:0] playerY,
  input  logic [9:0] playerW,
  input  logic [8:0] playerH,
  input  logic [9:0] pixX,
  input  logic [8:0] pixY,
  output logic       projPixel,
  output logic       playerHit,
  output logic [4:0] activeCount,
  output logic [7:0] dropCount,
  output logic       busy
);

  state_t                          state_q, state_d;
  logic [2:0]                      idx_q, idx_d;
  logic                            move_pending_q, move_pending_d;
  logic [c_num_entries-1:0][9:0]   buf_x_q, buf_x_d;
  logic [c_num_entries-1:0][8:0]   buf_y_q, buf_y_d;
  logic [9:0]                      buf_w_q, buf_w_d;
  logic [8:0]                      buf_h_q, buf_h_d;
  logic [7:0]                      drop_count_q, drop_count_d;
  logic [4:0]                      active_count_q, active_count_d;
  logic                            proj_pixel_q, proj_pixel_d;

  logic [c_num_entries-1:0][9:0]   entry_x;
  logic [c_num_entries-1:0][8:0]   entry_y;
  logic [NUM_SLOTS-1:0]            active_vec, offscreen_vec, hits_vec, covers_vec;
  logic [NUM_SLOTS-1:0]            free_vec, load_vec, kill_vec;
  logic                            free_found, spawn_req, move_en, hit_en;

  assign entry_x = {proj5X, proj4X, proj3X, proj2X, proj1X};
  assign entry_y = {proj5Y, proj4Y, proj3Y, proj2Y, proj1Y};

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    move_pending_d = move_pending_q;
    buf_x_d        = buf_x_q;
    buf_y_d        = buf_y_q;
    buf_w_d        = buf_w_q;
    buf_h_d        = buf_h_q;
    drop_count_d   = drop_count_q;
    spawn_req      = 1'b0;
    move_en        = 1'b0;
    hit_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bossShoot) begin
          buf_x_d        = entry_x;
          buf_y_d        = entry_y;
          buf_w_d        = projW;
          buf_h_d        = projH;
          idx_d          = 3'd0;
          move_pending_d = pulse_frame;
          state_d        = ST_SPAWN;
        end else if (pulse_frame) begin
          state_d = ST_MOVE;
        end
      end
      ST_SPAWN: begin
        if (pulse_frame) move_pending_d = 1'b1;
        // (0,0) marks an unused entry in the volley.
        if (buf_x_q[idx_q] != 10'd0 || buf_y_q[idx_q] != 9'd0) begin
          if (free_found) spawn_req = 1'b1;
          else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
        if (idx_q == 3'd4) begin
          state_d        = (move_pending_q || pulse_frame) ? ST_MOVE : ST_IDLE;
          move_pending_d = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_MOVE: begin
        move_en = 1'b1;
        state_d = ST_HIT;
      end
      ST_HIT: begin
        hit_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lowest-index free slot wins.
  always_comb begin
    free_vec   = ~active_vec;
    free_found = 1'b0;
    load_vec   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && free_vec[i]) begin
        load_vec[i] = spawn_req;
        free_found  = 1'b1;
      end
    end
  end

  always_comb begin
    active_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) active_count_d = active_count_d + 5'(active_vec[i]);
  end

  assign kill_vec     = ({NUM_SLOTS{move_en}} & offscreen_vec) | ({NUM_SLOTS{hit_en}} & hits_vec);
  assign proj_pixel_d = |covers_vec;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    proj_slot #(
      .PROJ_SPEED (PROJ_SPEED),
      .SCREEN_H   (SCREEN_H)
    ) u_slot (
      .clk          (clk_master),
      .rst          (rst),
      .load         (load_vec[g]),
      .load_x       (buf_x_q[idx_q]),
      .load_y       (buf_y_q[idx_q]),
      .load_w       (buf_w_q),
      .load_h       (buf_h_q),
      .move         (move_en),
      .kill         (kill_vec[g]),
      .player_x     (playerX),
      .player_y     (playerY),
      .player_w     (playerW),
      .player_h     (playerH),
      .pix_x        (pixX),
      .pix_y        (pixY),
      .active       (active_vec[g]),
      .offscreen    (offscreen_vec[g]),
      .hits_player  (hits_vec[g]),
      .covers_pixel (covers_vec[g])
    );
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      move_pending_q <= 1'b0;
      buf_x_q        <= '0;
      buf_y_q        <= '0;
      buf_w_q        <= '0;
      buf_h_q        <= '0;
      drop_count_q   <= '0;
      active_count_q <= '0;
      proj_pixel_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      move_pending_q <= move_pending_d;
      buf_x_q        <= buf_x_d;
      buf_y_q        <= buf_y_d;
      buf_w_q        <= buf_w_d;
      buf_h_q        <= buf_h_d;
      drop_count_q   <= drop_count_d;
      active_count_q <= active_count_d;
      proj_pixel_q   <= proj_pixel_d;
    end
  end

  assign projPixel   = proj_pixel_q;
  assign playerHit   = hit_en && (|hits_vec);
  assign activeCount = active_count_q;
  assign dropCount   = drop_count_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_boss_proj_manager.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_boss_proj_manager : self-checking bench for boss_proj_manager
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_boss_proj_manager;

  logic       clk_master = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_frame = 1'b0;
  logic       bossShoot = 1'b0;
  logic [9:0] proj1X = '0, proj2X = '0, proj3X = '0, proj4X = '0, proj5X = '0;
  logic [8:0] proj1Y = '0, proj2Y = '0, proj3Y = '0, proj4Y = '0, proj5Y = '0;
  logic [9:0] projW = '0;
  logic [8:0] projH = '0;
  logic [9:0] playerX = 10'd1000;
  logic [8:0] playerY = 9'd500;
  logic [9:0] playerW = 10'd1;
  logic [8:0] playerH = 9'd1;
  logic [9:0] pixX = '0;
  logic [8:0] pixY = '0;
  logic       projPixel, playerHit, busy;
  logic [4:0] activeCount;
  logic [7:0] dropCount;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       exp;
  } pix_vec_t;
  pix_vec_t pv[10];

  boss_proj_manager dut (
    .clk_master (clk_master), .rst (rst), .pulse_frame (pulse_frame), .bossShoot (bossShoot),
    .proj1X (proj1X), .proj1Y (proj1Y), .proj2X (proj2X), .proj2Y (proj2Y),
    .proj3X (proj3X), .proj3Y (proj3Y), .proj4X (proj4X), .proj4Y (proj4Y),
    .proj5X (proj5X), .proj5Y (proj5Y), .projW (projW), .projH (projH),
    .playerX (playerX), .playerY (playerY), .playerW (playerW), .playerH (playerH),
    .pixX (pixX), .pixY (pixY), .projPixel (projPixel), .playerHit (playerHit),
    .activeCount (activeCount), .dropCount (dropCount), .busy (busy)
  );

  always #5 clk_master = ~clk_master;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic set_coords(input logic [4:0][9:0] xs, input logic [4:0][8:0] ys,
                            input logic [9:0] w, input logic [8:0] h);
    proj1X = xs[0]; proj2X = xs[1]; proj3X = xs[2]; proj4X = xs[3]; proj5X = xs[4];
    proj1Y = ys[0]; proj2Y = ys[1]; proj3Y = ys[2]; proj4Y = ys[3]; proj5Y = ys[4];
    projW = w;
    projH = h;
  endtask

  task automatic send_volley(input logic [4:0][9:0] xs, input logic [4:0][8:0] ys,
                             input logic [9:0] w, input logic [8:0] h);
    set_coords(xs, ys, w, h);
    bossShoot = 1'b1;
    tick();
    bossShoot = 1'b0;
  endtask

  // Counts busy cycles and playerHit pulses until the FSM returns to IDLE.
  task automatic run_busy(output int nb, output int nh);
    nb = 0;
    nh = 0;
    for (int c = 0; c < 64 && busy; c++) begin
      nb++;
      if (playerHit) nh++;
      tick();
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=1, expected 0 within 64 cycles");
    end
  endtask

  task automatic frame(output int nb, output int nh);
    pulse_frame = 1'b1;
    tick();
    pulse_frame = 1'b0;
    run_busy(nb, nh);
  endtask

  task automatic pix_check(input string name, input logic [9:0] x, input logic [8:0] y, input logic e);
    pixX = x;
    pixY = y;
    exp_q.push_back(e);
    tick();
    check(name, int'(projPixel), int'(exp_q.pop_front()));
  endtask

  initial begin
    int nb, nh;
    logic [4:0][9:0] xs;
    logic [4:0][8:0] ys;

    pv[0] = '{10'd150, 9'd200, 1'b1};
    pv[1] = '{10'd159, 9'd214, 1'b1};
    pv[2] = '{10'd160, 9'd200, 1'b0};
    pv[3] = '{10'd150, 9'd215, 1'b0};
    pv[4] = '{10'd149, 9'd205, 1'b0};
    pv[5] = '{10'd490, 9'd210, 1'b1};
    pv[6] = '{10'd499, 9'd214, 1'b1};
    pv[7] = '{10'd300, 9'd100, 1'b0};
    pv[8] = '{10'd235, 9'd207, 1'b1};
    pv[9] = '{10'd320, 9'd199, 1'b0};

    // Reset state
    do_reset();
    check("rst_projPixel", int'(projPixel), 0);
    check("rst_playerHit", int'(playerHit), 0);
    check("rst_activeCount", int'(activeCount), 0);
    check("rst_dropCount", int'(dropCount), 0);
    check("rst_busy", int'(busy), 0);

    // Full five-entry volley
    send_volley({10'd490, 10'd405, 10'd320, 10'd235, 10'd150}, {5{9'd200}}, 10'd10, 9'd15);
    run_busy(nb, nh);
    check("t1_busy_cycles", nb, 5);
    tick();
    check("t1_activeCount", int'(activeCount), 5);
    check("t1_dropCount", int'(dropCount), 0);
    for (int i = 0; i < 10; i++) pix_check($sformatf("t1_pix%0d", i), pv[i].x, pv[i].y, pv[i].exp);

    // Empty fifth entry, plus a volley strobe while busy that must be ignored
    do_reset();
    send_volley({10'd0, 10'd100, 10'd70, 10'd40, 10'd10}, {9'd0, 9'd20, 9'd20, 9'd20, 9'd20}, 10'd8, 9'd8);
    tick();
    set_coords({5{10'd200}}, {5{9'd300}}, 10'd50, 9'd50);
    bossShoot = 1'b1;
    tick();
    bossShoot = 1'b0;
    run_busy(nb, nh);
    check("t2_busy_rest", nb, 3);
    tick();
    check("t2_activeCount", int'(activeCount), 4);
    check("t2_dropCount", int'(dropCount), 0);
    pix_check("t2_pix_origin", 10'd0, 9'd0, 1'b0);
    pix_check("t2_pix_ignored", 10'd210, 9'd310, 1'b0);
    pix_check("t2_pix_e4", 10'd107, 9'd27, 1'b1);

    // Pool exhaustion and drop counter saturation
    do_reset();
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 5; i++) begin
        xs[i] = 10'(20 + 40 * i);
        ys[i] = 9'(30 + 20 * v);
      end
      send_volley(xs, ys, 10'd5, 9'd5);
      run_busy(nb, nh);
    end
    tick();
    check("t3_activeCount_full", int'(activeCount), 16);
    check("t3_dropCount_4", int'(dropCount), 4);
    send_volley(xs, ys, 10'd5, 9'd5);
    run_busy(nb, nh);
    tick();
    check("t3_dropCount_9", int'(dropCount), 9);
    check("t3_activeCount_still", int'(activeCount), 16);
    for (int k = 0; k < 50; k++) begin
      send_volley(xs, ys, 10'd5, 9'd5);
      run_busy(nb, nh);
    end
    check("t3_dropCount_sat", int'(dropCount), 255);

    // Reset in the middle of SPAWN
    pixX = 10'd20;
    pixY = 9'd30;
    send_volley(xs, ys, 10'd5, 9'd5);
    tick();
    check("t3_pix_before_rst", int'(projPixel), 1);
    check("t3_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("t3_rst_busy", int'(busy), 0);
    check("t3_rst_activeCount", int'(activeCount), 0);
    check("t3_rst_dropCount", int'(dropCount), 0);
    check("t3_rst_projPixel", int'(projPixel), 0);
    rst = 1'b0;
    repeat (8) tick();
    check("t3_after_rst_busy", int'(busy), 0);
    check("t3_after_rst_activeCount", int'(activeCount), 0);
    check("t3_after_rst_pix", int'(projPixel), 0);

    // Retire at the bottom edge
    do_reset();
    send_volley({10'd0, 10'd0, 10'd0, 10'd0, 10'd100}, {9'd0, 9'd0, 9'd0, 9'd0, 9'd470}, 10'd10, 9'd5);
    run_busy(nb, nh);
    tick();
    check("t4_activeCount_1", int'(activeCount), 1);
    frame(nb, nh);
    check("t4_frame_busy", nb, 2);
    pix_check("t4_pix_474", 10'd100, 9'd474, 1'b1);
    pix_check("t4_pix_473", 10'd100, 9'd473, 1'b0);
    frame(nb, nh);
    pix_check("t4_pix_478", 10'd100, 9'd478, 1'b1);
    pix_check("t4_pix_477", 10'd100, 9'd477, 1'b0);
    check("t4_activeCount_kept", int'(activeCount), 1);
    frame(nb, nh);
    tick();
    check("t4_activeCount_retired", int'(activeCount), 0);
    pix_check("t4_pix_482", 10'd100, 9'd482, 1'b0);

    // Player collision; at y=204 the box ends at 219, one pixel short of the player
    do_reset();
    playerX = 10'd300; playerY = 9'd220; playerW = 10'd20; playerH = 9'd20;
    send_volley({10'd0, 10'd0, 10'd0, 10'd0, 10'd305}, {9'd0, 9'd0, 9'd0, 9'd0, 9'd200}, 10'd10, 9'd15);
    run_busy(nb, nh);
    frame(nb, nh);
    check("t5_no_hit_204", nh, 0);
    tick();
    check("t5_activeCount_kept", int'(activeCount), 1);
    pix_check("t5_pix_204", 10'd305, 9'd204, 1'b1);
    frame(nb, nh);
    check("t5_hit_pulses", nh, 1);
    tick();
    check("t5_activeCount_freed", int'(activeCount), 0);
    check("t5_hit_idle", int'(playerHit), 0);
    playerX = 10'd1000; playerY = 9'd500; playerW = 10'd1; playerH = 9'd1;

    // Ticks during SPAWN merge into one move; a tick during MOVE is lost
    do_reset();
    send_volley({10'd300, 10'd250, 10'd200, 10'd150, 10'd100}, {5{9'd100}}, 10'd4, 9'd4);
    nb = 0;
    for (int c = 0; c < 64 && busy; c++) begin
      nb++;
      pulse_frame = (c == 1 || c == 3);
      tick();
    end
    pulse_frame = 1'b0;
    check("t6_busy_spawn_move", nb, 7);
    check("t6_idle", int'(busy), 0);
    pix_check("t6_pix_104", 10'd100, 9'd104, 1'b1);
    pix_check("t6_pix_103", 10'd100, 9'd103, 1'b0);
    pix_check("t6_pix_e5", 10'd303, 9'd107, 1'b1);
    check("t6_activeCount", int'(activeCount), 5);
    pulse_frame = 1'b1;
    tick();
    tick();
    pulse_frame = 1'b0;
    run_busy(nb, nh);
    check("t6_lost_tick_busy", nb, 1);
    pix_check("t6_pix_108", 10'd100, 9'd108, 1'b1);
    pix_check("t6_pix_107", 10'd100, 9'd107, 1'b0);
    pix_check("t6_pix_112", 10'd100, 9'd112, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
